// File: rtl/acc_offload_issuer.sv
// Core-side initiator of the accelerator offload protocol: predecode query, hazard-checked issue, writeback return.
// Optional response checking (unexpected rd / no outstanding) is enabled by ACC_OFFLOAD_ISSUER_RSP_CHECK_EN.
module acc_offload_issuer #(
  parameter int unsigned NumRs          = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           instr_valid_i,
  output logic                           instr_ready_o,
  input  logic [31:0]                    instr_data_i,
  input  logic [NumRs*DataWidth-1:0]     rs_i,
  input  logic [NumRs-1:0]               rs_valid_i,
  output logic                           illegal_o,
  output logic [31:0]                    prd_q_instr_data_o,
  input  logic                           prd_p_accept_i,
  input  logic [1:0]                     prd_p_writeback_i,
  input  logic [NumRs-1:0]               prd_p_use_rs_i,
  output logic                           acc_q_valid_o,
  input  logic                           acc_q_ready_i,
  output logic [31:0]                    acc_q_instr_data_o,
  output logic [NumRs*DataWidth-1:0]     acc_q_rs_o,
  input  logic                           acc_p_valid_i,
  output logic                           acc_p_ready_o,
  input  logic [DataWidth-1:0]           acc_p_data_i,
  input  logic [4:0]                     acc_p_rd_i,
  output logic                           wb_valid_o,
  input  logic                           wb_ready_i,
  output logic [4:0]                     wb_rd_o,
  output logic [DataWidth-1:0]           wb_data_o,
  output logic [31:0]                    sb_o,
  output logic                           err_o
);

  localparam int unsigned RsWidth  = NumRs * DataWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state;
  logic [CntWidth-1:0] outstanding;
  logic [31:0]         sb;
  logic [31:0]         sb_next;
  logic [4:0]          rd;
  logic                wb;
  logic                rs_ok;
  logic                take;
  logic                p_hs;
  logic                wb_hs;
  logic                p_drop;
  logic                p_load;
  logic [RsWidth-1:0]  rs_masked;
  logic                unused_wb_hi;

  // Only the integer-rd writeback bit is meaningful to this core.
  assign unused_wb_hi = prd_p_writeback_i[1];

  assign rd    = instr_data_i[11:7];
  assign wb    = prd_p_writeback_i[0];
  assign rs_ok = &(rs_valid_i | ~prd_p_use_rs_i);
  assign take  = (state == IDLE) && instr_valid_i && prd_p_accept_i && rs_ok
               && !(wb && sb[rd]) && (outstanding < CntWidth'(MaxOutstanding));

  assign instr_ready_o      = (state == IDLE) && instr_valid_i && (!prd_p_accept_i || take);
  assign illegal_o          = (state == IDLE) && instr_valid_i && !prd_p_accept_i;
  assign prd_q_instr_data_o = instr_data_i;
  assign acc_p_ready_o      = !wb_valid_o || wb_ready_i;
  assign p_hs               = acc_p_valid_i && acc_p_ready_o;
  assign wb_hs              = wb_valid_o && wb_ready_i;
  assign sb_o               = sb;

  // Operands the instruction does not use are issued as zero.
  for (genvar k = 0; k < NumRs; k++) begin : g_rs
    assign rs_masked[k*DataWidth +: DataWidth] =
      prd_p_use_rs_i[k] ? rs_i[k*DataWidth +: DataWidth] : '0;
  end

`ifdef ACC_OFFLOAD_ISSUER_RSP_CHECK_EN
  logic err;

  assign p_drop = ((acc_p_rd_i != 5'd0) && !sb[acc_p_rd_i]) || (outstanding == '0);
  assign err_o  = err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (p_hs && p_drop) begin
      err <= 1'b1;
    end
  end
`else
  assign p_drop = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign p_load = p_hs && !p_drop && (acc_p_rd_i != 5'd0);

  // A set from a new take wins over a clear from a retiring writeback.
  always_comb begin
    sb_next = sb;
    if (wb_hs) sb_next[wb_rd_o] = 1'b0;
    if (take && wb && (rd != 5'd0)) sb_next[rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= IDLE;
      acc_q_valid_o      <= 1'b0;
      acc_q_instr_data_o <= '0;
      acc_q_rs_o         <= '0;
      wb_valid_o         <= 1'b0;
      wb_rd_o            <= '0;
      wb_data_o          <= '0;
      sb                 <= '0;
      outstanding        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state              <= ISSUE;
            acc_q_valid_o      <= 1'b1;
            acc_q_instr_data_o <= instr_data_i;
            acc_q_rs_o         <= rs_masked;
          end
        end
        ISSUE: begin
          if (acc_q_ready_i) begin
            state         <= IDLE;
            acc_q_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (p_load) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= acc_p_rd_i;
        wb_data_o  <= acc_p_data_i;
      end else if (wb_hs) begin
        wb_valid_o <= 1'b0;
      end

      sb <= sb_next;

      // Saturating decrement guards against a response with nothing in flight.
      if (take && !p_hs) begin
        outstanding <= outstanding + 1'b1;
      end else if (!take && p_hs && (outstanding != '0)) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_offload_issuer.sv
// Randomized scoreboard bench for acc_offload_issuer; follows ACC_OFFLOAD_ISSUER_RSP_CHECK_EN like the design.
module tb_acc_offload_issuer;

  localparam int unsigned NRS  = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 4;
  localparam int unsigned RSW  = NRS * DW;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_data_i;
  logic [RSW-1:0]  rs_i;
  logic [NRS-1:0]  rs_valid_i;
  logic            illegal_o;
  logic [31:0]     prd_q_instr_data_o;
  logic            prd_p_accept_i;
  logic [1:0]      prd_p_writeback_i;
  logic [NRS-1:0]  prd_p_use_rs_i;
  logic            acc_q_valid_o;
  logic            acc_q_ready_i;
  logic [31:0]     acc_q_instr_data_o;
  logic [RSW-1:0]  acc_q_rs_o;
  logic            acc_p_valid_i;
  logic            acc_p_ready_o;
  logic [DW-1:0]   acc_p_data_i;
  logic [4:0]      acc_p_rd_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [4:0]      wb_rd_o;
  logic [DW-1:0]   wb_data_o;
  logic [31:0]     sb_o;
  logic            err_o;

  acc_offload_issuer #(.NumRs(NRS), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_data_i(instr_data_i), .rs_i(rs_i), .rs_valid_i(rs_valid_i),
    .illegal_o(illegal_o), .prd_q_instr_data_o(prd_q_instr_data_o),
    .prd_p_accept_i(prd_p_accept_i), .prd_p_writeback_i(prd_p_writeback_i),
    .prd_p_use_rs_i(prd_p_use_rs_i),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_q_instr_data_o(acc_q_instr_data_o), .acc_q_rs_o(acc_q_rs_o),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
    .acc_p_data_i(acc_p_data_i), .acc_p_rd_i(acc_p_rd_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .sb_o(sb_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]    instr;
    logic [RSW-1:0] rs;
    logic [4:0]     rd;
    logic           wb;
  } req_t;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  // Reference model: pending request, per-register pending flags, in-flight count.
  bit          m_busy = 1'b0;
  req_t        m_req;
  logic [31:0] m_sb   = '0;
  int          m_out  = 0;
  bit          m_err  = 1'b0;
  rsp_t        wbq[$];
  rsp_t        rq[$];
  bit          resp_en  = 1'b0;
  int          resp_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Accelerator: result is the sum of the issued operands.
  function automatic logic [DW-1:0] acc_result(input req_t r);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < NRS; k++) s = s + r.rs[k*DW +: DW];
    return s;
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (resp_en && rq.size() != 0 && int'($urandom_range(99)) < resp_pct) begin
      acc_p_valid_i = 1'b1;
      acc_p_rd_i    = rq[0].rd;
      acc_p_data_i  = rq[0].data;
    end else begin
      acc_p_valid_i = 1'b0;
      acc_p_rd_i    = 5'($urandom);
      acc_p_data_i  = $urandom;
    end
  end

  // Monitor: compare DUT against the model, then advance the model by this cycle's events.
  always @(negedge clk_i) begin
    logic [4:0] rd_m;
    logic       wb_m, ok_rs, take, exp_ready, exp_ill, exp_pr, p_hs, wb_hs, q_hs, drop;
    req_t       r;
    rsp_t       p;
    if (rst_i) begin
      m_busy = 1'b0;
      m_sb   = '0;
      m_out  = 0;
      m_err  = 1'b0;
      wbq.delete();
      rq.delete();
    end else begin
      rd_m  = instr_data_i[11:7];
      wb_m  = prd_p_writeback_i[0];
      ok_rs = 1'b1;
      for (int k = 0; k < NRS; k++) if (prd_p_use_rs_i[k] && !rs_valid_i[k]) ok_rs = 1'b0;
      take = !m_busy && instr_valid_i && prd_p_accept_i && ok_rs
             && !(wb_m && m_sb[rd_m]) && (m_out < int'(MAXO));
      exp_ready = !m_busy && instr_valid_i && (!prd_p_accept_i || take);
      exp_ill   = !m_busy && instr_valid_i && !prd_p_accept_i;
      exp_pr    = (wbq.size() == 0) || wb_ready_i;

      chk("instr_ready", 64'(instr_ready_o), 64'(exp_ready));
      chk("illegal", 64'(illegal_o), 64'(exp_ill));
      chk("prd_q", 64'(prd_q_instr_data_o), 64'(instr_data_i));
      chk("acc_q_valid", 64'(acc_q_valid_o), 64'(m_busy));
      if (m_busy) begin
        chk("acc_q_instr", 64'(acc_q_instr_data_o), 64'(m_req.instr));
        chk("acc_q_rs", 64'(acc_q_rs_o), 64'(m_req.rs));
      end
      chk("sb", 64'(sb_o), 64'(m_sb));
      chk("wb_valid", 64'(wb_valid_o), 64'(wbq.size() != 0));
      chk("acc_p_ready", 64'(acc_p_ready_o), 64'(exp_pr));
      if (wbq.size() != 0) begin
        chk("wb_rd", 64'(wb_rd_o), 64'(wbq[0].rd));
        chk("wb_data", 64'(wb_data_o), 64'(wbq[0].data));
      end
      chk("err", 64'(err_o), 64'(m_err));

      p_hs  = acc_p_valid_i && exp_pr;
      wb_hs = (wbq.size() != 0) && wb_ready_i;
      q_hs  = m_busy && acc_q_ready_i;
      drop  = 1'b0;
`ifdef ACC_OFFLOAD_ISSUER_RSP_CHECK_EN
      if (p_hs && (((acc_p_rd_i != 5'd0) && !m_sb[acc_p_rd_i]) || m_out == 0)) begin
        drop  = 1'b1;
        m_err = 1'b1;
      end
`endif
      if (wb_hs) begin
        m_sb[wbq[0].rd] = 1'b0;
        void'(wbq.pop_front());
      end
      if (p_hs) begin
        p.rd   = acc_p_rd_i;
        p.data = acc_p_data_i;
        if (!drop && p.rd != 5'd0) wbq.push_back(p);
        if (rq.size() != 0) void'(rq.pop_front());
      end
      if (q_hs) begin
        m_busy = 1'b0;
        p.rd   = m_req.wb ? m_req.rd : 5'd0;
        p.data = acc_result(m_req);
        rq.push_back(p);
      end
      if (take) begin
        r.instr = instr_data_i;
        r.rd    = rd_m;
        r.wb    = wb_m;
        r.rs    = '0;
        for (int k = 0; k < NRS; k++)
          if (prd_p_use_rs_i[k]) r.rs[k*DW +: DW] = rs_i[k*DW +: DW];
        m_req  = r;
        m_busy = 1'b1;
        if (wb_m && rd_m != 5'd0) m_sb[rd_m] = 1'b1;
        m_out++;
      end
      if (p_hs && m_out > 0) m_out--;
    end
  end

  task automatic wait_wb(input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!wb_valid_o && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 64'(wb_valid_o), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    instr_valid_i = 1'b0;
    acc_q_ready_i = 1'b1;
    wb_ready_i    = 1'b1;
    resp_en       = 1'b1;
    resp_pct      = 100;
    rst_i         = 1'b0;
    while ((m_busy || rq.size() != 0 || wbq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    @(negedge clk_i);
    chk("drain_sb", 64'(sb_o), 64'd0);
    chk("drain_q_valid", 64'(acc_q_valid_o), 64'd0);
    chk("drain_wb_valid", 64'(wb_valid_o), 64'd0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_q_valid"}, 64'(acc_q_valid_o), 64'd0);
    chk({name, "_q_instr"}, 64'(acc_q_instr_data_o), 64'd0);
    chk({name, "_q_rs"}, 64'(acc_q_rs_o), 64'd0);
    chk({name, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
    chk({name, "_wb_rd"}, 64'(wb_rd_o), 64'd0);
    chk({name, "_wb_data"}, 64'(wb_data_o), 64'd0);
    chk({name, "_sb"}, 64'(sb_o), 64'd0);
    chk({name, "_err"}, 64'(err_o), 64'd0);
    chk({name, "_ready"}, 64'(instr_ready_o), 64'd0);
    chk({name, "_illegal"}, 64'(illegal_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    instr_valid_i = 1'b0; instr_data_i = '0; rs_i = '0; rs_valid_i = '0;
    prd_p_accept_i = 1'b0; prd_p_writeback_i = '0; prd_p_use_rs_i = '0;
    acc_q_ready_i = 1'b0; wb_ready_i = 1'b0;
    acc_p_valid_i = 1'b0; acc_p_rd_i = '0; acc_p_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_zero("reset");

    // Predecoder rejection pulses illegal for one cycle only.
    step();
    instr_valid_i = 1'b1; instr_data_i = 32'h0000_0000; prd_p_accept_i = 1'b0;
    @(negedge clk_i);
    chk("rej_illegal", 64'(illegal_o), 64'd1);
    chk("rej_ready", 64'(instr_ready_o), 64'd1);
    step();
    instr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rej_pulse", 64'(illegal_o), 64'd0);
    chk("rej_no_q", 64'(acc_q_valid_o), 64'd0);
    chk("rej_sb", 64'(sb_o), 64'd0);

    // Accepted rd=10 instruction with a stalled request channel.
    step();
    instr_valid_i = 1'b1; instr_data_i = 32'h00B5_0533; prd_p_accept_i = 1'b1;
    prd_p_writeback_i = 2'b01; prd_p_use_rs_i = 2'b11; rs_valid_i = 2'b11;
    rs_i = {32'd7, 32'd5}; acc_q_ready_i = 1'b0; wb_ready_i = 1'b0;
    resp_en = 1'b1; resp_pct = 100;
    @(negedge clk_i);
    chk("take_ready", 64'(instr_ready_o), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_valid", 64'(acc_q_valid_o), 64'd1);
      chk("stall_instr", 64'(acc_q_instr_data_o), 64'h00B5_0533);
      chk("stall_rs", 64'(acc_q_rs_o), {32'd7, 32'd5});
      chk("stall_sb10", 64'(sb_o[10]), 64'd1);
      step();
    end
    acc_q_ready_i = 1'b1;
    step();
    acc_q_ready_i = 1'b0;
    wait_wb("wb1_timeout");
    chk("wb1_rd", 64'(wb_rd_o), 64'd10);
    chk("wb1_data", 64'(wb_data_o), 64'd12);
    chk("wb1_p_ready", 64'(acc_p_ready_o), 64'd0);
    chk("haz_ready", 64'(instr_ready_o), 64'd0);
    step();
    step();
    wb_ready_i = 1'b1;
    @(negedge clk_i);
    chk("haz_clear_cycle", 64'(instr_ready_o), 64'd0);
    step();
    @(negedge clk_i);
    chk("sb10_cleared", 64'(sb_o[10]), 64'd0);
    chk("haz_next_cycle", 64'(instr_ready_o), 64'd1);
    step();
    instr_valid_i = 1'b0; wb_ready_i = 1'b0; acc_q_ready_i = 1'b1;
    step();
    acc_q_ready_i = 1'b0;
    wait_wb("wb2_timeout");
    chk("wb2_p_ready", 64'(acc_p_ready_o), 64'd0);
    step();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero("midrst");
    step();
    rst_i = 1'b0;

    // In-flight limit: no responses, so the fifth take must stall.
    resp_en = 1'b0; acc_q_ready_i = 1'b1; wb_ready_i = 1'b1;
    instr_valid_i = 1'b1; prd_p_accept_i = 1'b1; prd_p_writeback_i = 2'b00;
    prd_p_use_rs_i = 2'b01; rs_valid_i = 2'b11;
    for (int i = 0; i < 12; i++) begin
      instr_data_i = $urandom;
      rs_i = {$urandom, $urandom};
      step();
    end
    @(negedge clk_i);
    chk("max_stall", 64'(instr_ready_o), 64'd0);
    resp_en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    drain();

    // Response for a register with no pending writeback.
    rq.push_back('{rd: 5'd3, data: 32'h1234_5678});
`ifdef ACC_OFFLOAD_ISSUER_RSP_CHECK_EN
    for (int i = 0; i < 5; i++) step();
    @(negedge clk_i);
    chk("spur_err", 64'(err_o), 64'd1);
    chk("spur_no_wb", 64'(wb_valid_o), 64'd0);
    step();
    @(negedge clk_i);
    chk("spur_err_sticky", 64'(err_o), 64'd1);
`else
    wait_wb("spur_wb_timeout");
    chk("spur_wb_rd", 64'(wb_rd_o), 64'd3);
    chk("spur_wb_data", 64'(wb_data_o), 64'h1234_5678);
`endif
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;

    // Random traffic with occasional mid-operation resets.
    resp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      instr_valid_i     = int'($urandom_range(99)) < 70;
      instr_data_i      = $urandom;
      instr_data_i[11:7] = 5'($urandom_range(6));
      prd_p_accept_i    = int'($urandom_range(99)) < 80;
      prd_p_writeback_i = 2'($urandom);
      prd_p_use_rs_i    = 2'($urandom);
      rs_valid_i        = (int'($urandom_range(99)) < 85) ? 2'b11 : 2'($urandom);
      rs_i              = {$urandom, $urandom};
      acc_q_ready_i     = int'($urandom_range(99)) < 60;
      wb_ready_i        = int'($urandom_range(99)) < 70;
      rst_i             = ($urandom_range(999) == 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_offload_issuer.md
# acc_offload_issuer

Core-side initiator of the accelerator offload protocol. It takes one instruction at a time from the core, queries the accelerator predecoder, and issues accepted instructions on the accelerator request channel with their source operands. It tracks destination registers with pending writebacks, which blocks hazards, and returns accelerator results to the core register-file write port. It sits between the core's decode/issue stage, the predecoder responder and the accelerator interconnect.

## Interface
- NumRs, default 2: number of source operands per instruction (2 or 3).
- DataWidth, default 32: operand and result width.
- MaxOutstanding, default 4: maximum number of in-flight offloaded instructions (≥1).
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- instr_valid_i / instr_ready_o  in/out  1  instruction handshake from the core.
- instr_data_i  in  32  instruction word.
- rs_i  in  NumRs×DataWidth  source operand values.
- rs_valid_i  in  NumRs  per-operand forwarding-valid flags.
- illegal_o  out  1  one-cycle pulse: the instruction was rejected by the predecoder.
- prd_q_instr_data_o  out  32  predecoder query; combinationally equal to instr_data_i.
- prd_p_accept_i, prd_p_writeback_i[1:0], prd_p_use_rs_i[NumRs-1:0]  in  predecoder response. Only bit 0 of prd_p_writeback_i (integer rd) is used.
- acc_q_valid_o / acc_q_ready_i  out/in  1  accelerator request handshake.
- acc_q_instr_data_o  out  32; acc_q_rs_o  out  NumRs×DataWidth  request payload.
- acc_p_valid_i / acc_p_ready_o  in/out  1  accelerator response handshake.
- acc_p_data_i  in  DataWidth; acc_p_rd_i  in  5  response result and destination register.
- wb_valid_o / wb_ready_i  out/in  1  register-file writeback handshake.
- wb_rd_o  out  5; wb_data_o  out  DataWidth  writeback payload.
- sb_o  out  32  pending-writeback scoreboard; bit 0 is always 0.
- err_o  out  1  sticky error flag (see Configuration).

## Operation
- The FSM has two states, IDLE and ISSUE.
- IDLE, instr_valid_i=1, prd_p_accept_i=0: instr_ready_o=1 and illegal_o=1 in the same cycle. The FSM stays in IDLE.
- IDLE, accepted instruction: define rd = instr_data_i[11:7] and wb = prd_p_writeback_i[0]. The instruction is taken (instr_ready_o=1) only when all three conditions hold:
  - rs_valid_i[k] is 1 for every k with prd_p_use_rs_i[k]=1;
  - (wb=0 or sb_o[rd]=0);
  - outstanding < MaxOutstanding.
- On take: latch the instruction and rs_i into the request registers, with unused operands zeroed. Set sb[rd] if wb=1 and rd≠0. Increment outstanding. Go to ISSUE.
- Otherwise instr_ready_o=0 and nothing changes (stall).
- ISSUE: acc_q_valid_o=1 and the payload is held stable until acc_q_ready_i=1, then the FSM returns to IDLE. instr_ready_o=0 while in ISSUE.
- Response path: a 1-entry writeback register. acc_p_ready_o = !wb_valid_o || wb_ready_i.
  - On a p handshake: load rd/data and set wb_valid_o.
  - On a wb handshake: clear wb_valid_o (unless reloaded the same cycle) and clear sb[wb_rd_o].
- Outstanding decrements on a p handshake. A simultaneous take and p handshake leaves it unchanged.
- A response with acc_p_rd_i=0 is consumed, decrements outstanding, and produces no writeback.

## Timing
- Reset: FSM=IDLE. instr_ready_o, illegal_o, acc_q_valid_o, wb_valid_o and err_o are 0. sb_o=0, outstanding=0, and all payload registers are 0.
- Reset asserted mid-operation discards the in-flight request, the pending writeback and the scoreboard.
- Take in cycle N gives acc_q_valid_o=1 from cycle N+1. The minimum issue interval is 2 cycles per instruction.
- A p handshake in cycle N gives wb_valid_o=1 in cycle N+1. A back-to-back response stream runs at 1 per cycle when wb_ready_i=1.
- The sb bit set by a take is visible at cycle N+1. A clear in cycle N allows a take of the same rd in cycle N+1, not N.
- illegal_o and instr_ready_o depend combinationally on the predecoder inputs. acc_q_* and wb_* outputs are registered.

## Configuration
- The macro is ACC_OFFLOAD_ISSUER_RSP_CHECK_EN.
- When defined: a response whose acc_p_rd_i≠0 has sb_o[acc_p_rd_i]=0, or that arrives with outstanding=0, is consumed and dropped with no writeback. err_o is set and stays set until reset.
- When undefined: no check is made, every response is written back as normal, and err_o is tied to 0.

## Test plan
- Predecoder rejects 0x0000_0000 → illegal_o pulses for 1 cycle, acc_q_valid_o stays 0, and sb_o=0.
- Accepted instr 0x00B5_0533 (rd=10), wb=1, use_rs=2'b11, rs=5/7, acc_q_ready_i held 0 for 3 cycles → payload stable through the stall. sb_o[10]=1 from the cycle after the take. After the response rd=10, data=12: wb_rd_o=10, wb_data_o=12, then sb_o[10]=0.
- Second instruction with rd=10 while sb_o[10]=1 → instr_ready_o=0 until the cycle after the writeback handshake.
- MaxOutstanding=4, 4 takes with no responses → the 5th stalls. One response frees the slot and the next take proceeds.
- wb_ready_i=0 with wb_valid_o=1 → acc_p_ready_o=0. Asserting rst_i in that cycle → all outputs and sb_o are 0 on the next cycle.
- With the macro defined, a response rd=3 while sb_o[3]=0 → no wb_valid_o, and err_o=1 sticky. With the macro undefined → writeback of rd=3 occurs.
